// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one single-word read/write command in flight, result on a valid/ready port.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN (otherwise rsp_timeout_o is 0).
module axil_cmd_master #(
    parameter int unsigned ADDR_W         = 21,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    output logic                  rsp_timeout_o,
    output logic                  m_axil_awvalid_o,
    input  logic                  m_axil_awready_i,
    output logic [ADDR_W-1:0]     m_axil_awaddr_o,
    output logic [2:0]            m_axil_awprot_o,
    output logic                  m_axil_wvalid_o,
    input  logic                  m_axil_wready_i,
    output logic [DATA_W-1:0]     m_axil_wdata_o,
    output logic [DATA_W/8-1:0]   m_axil_wstrb_o,
    input  logic                  m_axil_bvalid_i,
    output logic                  m_axil_bready_o,
    input  logic [1:0]            m_axil_bresp_i,
    output logic                  m_axil_arvalid_o,
    input  logic                  m_axil_arready_i,
    output logic [ADDR_W-1:0]     m_axil_araddr_o,
    output logic [2:0]            m_axil_arprot_o,
    input  logic                  m_axil_rvalid_i,
    output logic                  m_axil_rready_o,
    input  logic [DATA_W-1:0]     m_axil_rdata_i,
    input  logic [1:0]            m_axil_rresp_i
);

    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StRsp} state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  accept;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_timeout_q, rsp_timeout_d;
`endif

    assign accept = cmd_valid_i && cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            StIdle: begin
                // Also raises cmd_ready on the first edge after reset release.
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    wstrb_d     = cmd_wstrb_i;
                    if (cmd_write_i) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                if (awvalid_q && m_axil_awready_i) awvalid_d = 1'b0;
                if (wvalid_q && m_axil_wready_i)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (m_axil_bvalid_i) begin
                    state_d     = StRsp;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axil_bresp_i;
                    rsp_rdata_d = '0;
                end
            end
            StRdReq: begin
                if (m_axil_arready_i) begin
                    state_d   = StRdResp;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdResp: begin
                if (m_axil_rvalid_i) begin
                    state_d     = StRsp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axil_rresp_i;
                    rsp_rdata_d = m_axil_rdata_i;
                end
            end
            StRsp: begin
                if (rsp_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
        if (state_q == StIdle && accept) begin
            cnt_d         = '0;
            rsp_timeout_d = 1'b0;
        end else if (state_q inside {StWrReq, StWrResp, StRdReq, StRdResp}) begin
            cnt_d = cnt_q + 1'b1;
            // Fires in the busy cycle that puts rsp_valid exactly TIMEOUT_CYCLES after accept;
            // a completing handshake (state change) takes priority.
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 2) && state_d == state_q) begin
                state_d       = StRsp;
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                bready_d      = 1'b0;
                arvalid_d     = 1'b0;
                rready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_resp_d    = 2'b11;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout_o = rsp_timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

    assign cmd_ready_o      = cmd_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_rdata_o      = rsp_rdata_q;
    assign rsp_resp_o       = rsp_resp_q;
    assign m_axil_awvalid_o = awvalid_q;
    assign m_axil_awaddr_o  = addr_q;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_wvalid_o  = wvalid_q;
    assign m_axil_wdata_o   = wdata_q;
    assign m_axil_wstrb_o   = wstrb_q;
    assign m_axil_bready_o  = bready_q;
    assign m_axil_arvalid_o = arvalid_q;
    assign m_axil_araddr_o  = addr_q;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_rready_o  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: randomized commands, reactive AXI-Lite slave, scoreboard monitor.
module tb_axil_cmd_master;
    localparam int AW  = 21;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [1:0]    bresp = '0, rresp = '0;
    logic [DW-1:0] rdata = '0;

    always #5 clk = ~clk;

    axil_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
        .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready), .m_axil_awaddr_o(awaddr),
        .m_axil_awprot_o(awprot), .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready),
        .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_bvalid_i(bvalid),
        .m_axil_bready_o(bready), .m_axil_bresp_i(bresp), .m_axil_arvalid_o(arvalid),
        .m_axil_arready_i(arready), .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot),
        .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready), .m_axil_rdata_i(rdata),
        .m_axil_rresp_i(rresp)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
        bit            hang;
    } txn_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        bit            tmo;
        int            lat;
        int            acc;
    } exp_t;

    txn_t slv_q[$];
    exp_t exp_q[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0;
    int   hold_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: response contents and cycle latency from the protocol rules alone.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.acc   = 0;
        e.tmo   = 1'b0;
        e.resp  = t.resp;
        e.rdata = t.wr ? '0 : t.rdata;
        if (t.wr) e.lat = 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
        else      e.lat = 3 + t.ar_dly + t.r_dly;
        if (t.hang) begin
            e.tmo   = 1'b1;
            e.resp  = 2'b11;
            e.rdata = '0;
            e.lat   = TMO;
        end
        return e;
    endfunction

    function automatic txn_t mk(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                input logic [SW-1:0] strb, input logic [DW-1:0] rd,
                                input logic [1:0] resp);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wd; t.strb = strb; t.rdata = rd; t.resp = resp;
        t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.ar_dly = 0; t.r_dly = 0; t.hang = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t = mk($urandom_range(0, 1) == 1, AW'($urandom) & ~AW'(3), $urandom, SW'($urandom),
               $urandom, 2'($urandom));
        t.aw_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3);
        t.b_dly  = $urandom_range(0, 2); t.ar_dly = $urandom_range(0, 3);
        t.r_dly  = $urandom_range(0, 2);
        return t;
    endfunction

    task automatic issue(input txn_t t, output bit ok);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = t.wr; cmd_addr = t.addr;
        cmd_wdata = t.wdata; cmd_wstrb = t.strb;
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        ok = cmd_ready;
        if (!cmd_ready) begin
            chk("cmd_accept_wait", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        slv_q.push_back(t);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
        e = model(t);
        e.acc = cyc - 1;
        exp_q.push_back(e);
    endtask

    // Slave side: readies/valids driven on the falling edge, handshakes land on the next rise.
    task automatic slave_write(input txn_t t);
        bit aw_done, w_done;
        int c;
        aw_done = 1'b0; w_done = 1'b0; c = 0;
        while (!(aw_done && w_done)) begin
            if (!rst_n || (t.hang && !awvalid && !wvalid) || c > 300) begin
                if (rst_n && !t.hang) chk("slv_wr_bound", 0, 1);
                awready = 1'b0; wready = 1'b0;
                return;
            end
            awready = 1'b0; wready = 1'b0;
            if (aw_done) chk("aw_single", awvalid, 0);
            else if (awvalid && !t.hang && c >= t.aw_dly) begin
                awready = 1'b1; aw_done = 1'b1;
                chk("awaddr", awaddr, t.addr);
                chk("awprot", awprot, 0);
            end
            if (w_done) chk("w_single", wvalid, 0);
            else if (wvalid && !t.hang && c >= t.w_dly) begin
                wready = 1'b1; w_done = 1'b1;
                chk("wdata", wdata, t.wdata);
                chk("wstrb", wstrb, t.strb);
            end
            @(negedge clk);
            c++;
        end
        awready = 1'b0; wready = 1'b0;
        chk("aw_single", awvalid, 0);
        chk("w_single", wvalid, 0);
        for (int i = 0; i < t.b_dly; i++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        bvalid = 1'b1; bresp = t.resp; c = 0;
        while (!bready && c < 300) begin
            @(negedge clk);
            c++;
            if (!rst_n) begin bvalid = 1'b0; return; end
        end
        if (!bready) chk("bready_wait", 0, 1);
        @(negedge clk);
        bvalid = 1'b0; bresp = '0;
    endtask

    task automatic slave_read(input txn_t t);
        int c;
        for (int i = 0; i < t.ar_dly; i++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        chk("arvalid_held", arvalid, 1);
        chk("araddr", araddr, t.addr);
        chk("arprot", arprot, 0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        if (!rst_n) return;
        chk("ar_single", arvalid, 0);
        for (int i = 0; i < t.r_dly; i++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        rvalid = 1'b1; rdata = t.rdata; rresp = t.resp; c = 0;
        while (!rready && c < 300) begin
            @(negedge clk);
            c++;
            if (!rst_n) begin rvalid = 1'b0; return; end
        end
        if (!rready) chk("rready_wait", 0, 1);
        @(negedge clk);
        rvalid = 1'b0; rdata = '0; rresp = '0;
    endtask

    initial begin : slave
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst_n && slv_q.size() > 0 && (awvalid || wvalid || arvalid)) begin
                t = slv_q.pop_front();
                chk("slv_dir", awvalid | wvalid, t.wr);
                if (t.wr) slave_write(t);
                else      slave_read(t);
            end
        end
    end

    initial begin : monitor
        exp_t          e;
        bit            pending;
        logic [DW-1:0] h_rdata;
        logic [1:0]    h_resp;
        logic          h_tmo;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0; rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                chk("cmd_ready_in_rsp", cmd_ready, 0);
                if (!pending) begin
                    if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", rsp_resp, e.resp);
                        chk("rsp_timeout", rsp_timeout, e.tmo);
                        chk("rsp_latency", cyc - e.acc, e.lat);
                    end
                    pending = 1'b1;
                    h_rdata = rsp_rdata; h_resp = rsp_resp; h_tmo = rsp_timeout;
                end else begin
                    chk("rsp_rdata_stable", rsp_rdata, h_rdata);
                    chk("rsp_resp_stable", rsp_resp, h_resp);
                    chk("rsp_timeout_stable", rsp_timeout, h_tmo);
                end
                if (hold_n > 0) begin
                    rsp_ready = 1'b0;
                    hold_n--;
                end else rsp_ready = 1'($urandom_range(0, 1));
                if (rsp_ready) pending = 1'b0;
            end else rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
    endtask

    initial begin : stim
        txn_t t;
        bit   ok;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // Zero-wait write, then read with slow arready.
        issue(mk(1'b1, AW'('h4), 32'hDEADBEEF, 4'hF, '0, 2'b00), ok);
        t = mk(1'b0, AW'('h10), '0, '0, 32'h12345678, 2'b00);
        t.ar_dly = 5;
        issue(t, ok);
        // W before AW, then AW before W.
        t = mk(1'b1, AW'('h20), 32'hA5A5_0001, 4'h3, '0, 2'b00);
        t.aw_dly = 3;
        issue(t, ok);
        t = mk(1'b1, AW'('h24), 32'h5A5A_0002, 4'hC, '0, 2'b01);
        t.w_dly = 3;
        issue(t, ok);
        drain();
        // SLVERR with consumer stalling.
        hold_n = 4;
        issue(mk(1'b1, AW'('h30), 32'h0BAD_F00D, 4'h1, '0, 2'b10), ok);
        drain();
        // Reset while waiting for R; abandoned transaction yields no response.
        t = mk(1'b0, AW'('h40), '0, '0, 32'hCAFE_0000, 2'b00);
        t.r_dly = 20;
        issue(t, ok);
        repeat (3) @(negedge clk);
        chk("rready_pre_rst", rready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valids", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("midrst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", cmd_ready, 1);
        issue(mk(1'b0, AW'('h44), '0, '0, 32'h1357_9BDF, 2'b11), ok);
        drain();

        for (int i = 0; i < 40; i++) issue(rand_txn(), ok);
        drain();

`ifdef AXIL_MASTER_TIMEOUT_EN
        t = mk(1'b1, AW'('h80), 32'h7777_7777, 4'hF, '0, 2'b00);
        t.hang = 1'b1;
        issue(t, ok);
        drain();
        issue(mk(1'b0, AW'('h84), '0, '0, 32'h2468_ACE0, 2'b00), ok);
        drain();
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
